fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_SIZE, default 1024; instruction memory size in bytes, power of two, >4.
REQ-002 Parameter RESET_PC, default 64'h0; first fetch address after reset, word-aligned.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard stall from decode; hold PC and IF/ID register.
REQ-006 br_taken  input  1  redirect request from a later stage.
REQ-007 br_target  input  64  redirect byte address.
REQ-008 halt_req  input  1  stop fetching (end of program).
REQ-009 imem_addr  output  64  byte address to instruction memory (combinational read).
REQ-010 imem_instr  input  32  instruction returned for imem_addr in the same cycle.
REQ-011 ifid_pc  output  64  PC of the instruction held in IF/ID.
REQ-012 ifid_instr  output  32  instruction held in IF/ID.
REQ-013 ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-014 fault  output  1  sticky; PC misaligned or out of bounds.
REQ-015 fetch_count  output  32  count of instructions latched into IF/ID.

Function
REQ-016 State machine, states BOOT, RUN, HALT, FAULT.
REQ-017 BOOT: one cycle after reset release; imem_addr = PC; no IF/ID load; next state RUN.
REQ-018 RUN, no redirect, stall=0: IF/ID <= {PC, imem_instr, valid=1}; PC <= PC+4; fetch_count += 1.
REQ-019 RUN, stall=1, br_taken=0: PC, IF/ID, fetch_count hold.
REQ-020 RUN, br_taken=1 (priority over stall): PC <= br_target; ifid_valid <= 0; ifid_pc/ifid_instr hold; fetch_count holds.
REQ-021 imem_addr = PC combinationally in every state.
REQ-022 PC arithmetic modulo 2^64; no carry out.
REQ-023 Bounds check on PC in RUN: PC[1:0] != 0 or PC+3 >= IMEM_SIZE -> next state FAULT, fault <= 1, no IF/ID load, ifid_valid <= 0.
REQ-024 br_target misaligned or out of bounds: redirect accepted, fault detected on the following cycle per REQ-023.
REQ-025 halt_req=1 in RUN (and br_taken=0): next state HALT, ifid_valid <= 0, PC holds.
REQ-026 br_taken=1 and halt_req=1 same cycle: redirect wins; halt_req re-sampled next cycle.
REQ-027 HALT and FAULT: terminal until reset; PC, IF/ID, fetch_count hold; ifid_valid=0; br_taken, stall ignored.
REQ-028 fetch_count saturates at 32'hFFFF_FFFF.
REQ-029 No X may reach ifid_valid or fault; X on imem_instr is latched only when valid load occurs.

Reset
REQ-030 reset asserted (any time, incl. mid-stall or mid-redirect): state BOOT, PC = RESET_PC, ifid_pc = 0, ifid_instr = 0, ifid_valid = 0, fault = 0, fetch_count = 0, immediately, without clock edge.
REQ-031 First IF/ID load occurs on the second posedge after reset deassertion.

Verification
REQ-032 Reset, imem returns word = address: after 4 RUN cycles -> ifid_pc = 0x0C, ifid_instr = 0x0C, fetch_count = 4, imem_addr = 0x10.
REQ-033 stall=1 for 3 cycles at PC 0x08 -> imem_addr stays 0x08, IF/ID and fetch_count unchanged; release -> ifid_pc = 0x08 next edge.
REQ-034 br_taken=1, br_target=0x40 while stall=1 -> next cycle imem_addr = 0x40, ifid_valid = 0; following edge ifid_pc = 0x40, ifid_valid = 1.
REQ-035 br_target = 0x3FE (IMEM_SIZE 1024) -> one cycle later fault = 1, state FAULT, ifid_valid = 0; stays until reset.
REQ-036 Sequential fetch to PC 0x3FC -> loaded normally; PC 0x400 -> fault = 1, fetch_count = 256.
REQ-037 halt_req pulse at PC 0x20 -> ifid_valid = 0, imem_addr frozen at 0x20; async reset mid-HALT -> all outputs per REQ-030 before next posedge.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of an in-order pipeline. Holds the program counter,
// drives a combinational-read instruction memory, and loads the IF/ID
// pipeline register. A small FSM sequences one boot cycle after reset, then
// fetches until the program halts or the PC leaves the instruction memory.
//
// Parameters
//   IMEM_SIZE  instruction memory size in bytes (power of two, > 4)
//   RESET_PC   first fetch address after reset (word aligned)
//
// Ports
//   clk          in   single clock, all state changes on posedge
//   reset        in   asynchronous, active-high reset
//   stall        in   decode hazard stall: hold PC and IF/ID
//   br_taken     in   redirect request from a later stage
//   br_target    in   redirect byte address
//   halt_req     in   stop fetching (end of program)
//   imem_addr    out  byte address to instruction memory (= PC)
//   imem_instr   in   instruction for imem_addr, same cycle
//   ifid_pc      out  PC of the instruction held in IF/ID
//   ifid_instr   out  instruction held in IF/ID
//   ifid_valid   out  IF/ID holds a real instruction (0 = bubble)
//   fault        out  sticky: PC misaligned or out of bounds
//   fetch_count  out  saturating count of instructions loaded into IF/ID
//   dbg_state    out  current FSM state (0 BOOT, 1 RUN, 2 HALT, 3 FAULT)
//
// Handshake: IF/ID is offered to decode whenever ifid_valid=1. Decode
// back-pressures with stall=1, which holds ifid_pc/ifid_instr/ifid_valid
// unchanged; the entry is consumed on any edge where stall=0. A redirect
// (br_taken=1) overrides stall and replaces the entry with a bubble.
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int unsigned IMEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC  = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   input  logic        halt_req,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        fault,
   output logic [31:0] fetch_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   // Bound compared in 65 bits so PC+3 can never wrap back into range.
   localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_SIZE);

   state_e      state_q,       state_d;
   logic [63:0] pc_q,          pc_d;
   logic [63:0] ifid_pc_q,     ifid_pc_d;
   logic [31:0] ifid_instr_q,  ifid_instr_d;
   logic        ifid_valid_q,  ifid_valid_d;
   logic        fault_q,       fault_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic [64:0] pc_last_byte;
   logic        pc_misaligned;
   logic        pc_out_of_bounds;
   logic        pc_bad;
   logic [63:0] pc_plus4;
   logic [31:0] count_inc;

   // ------------------------------------------------------------------------
   // PC checks and arithmetic
   // ------------------------------------------------------------------------
   assign pc_last_byte     = {1'b0, pc_q} + 65'd3;
   assign pc_misaligned    = (pc_q[1:0] != 2'b00);
   assign pc_out_of_bounds = (pc_last_byte >= IMEM_LIMIT);
   assign pc_bad           = pc_misaligned | pc_out_of_bounds;

   // Wraps modulo 2^64; the carry out is intentionally dropped.
   assign pc_plus4 = pc_q + 64'd4;

   // Saturates at all-ones instead of wrapping to zero.
   assign count_inc = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                       : fetch_count_q + 32'd1;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_valid_d  = ifid_valid_q;
      fault_d       = fault_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         // One idle cycle so the first fetch address is presented to the
         // memory before anything is latched.
         ST_BOOT: begin
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (pc_bad) begin
               // The current PC cannot be fetched; nothing is loaded.
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               ifid_valid_d = 1'b0;
            end else if (br_taken) begin
               // Redirect beats stall and halt; a bad target is caught by
               // the bounds check on the next cycle.
               pc_d         = br_target;
               ifid_valid_d = 1'b0;
            end else if (halt_req) begin
               state_d      = ST_HALT;
               ifid_valid_d = 1'b0;
            end else if (!stall) begin
               ifid_pc_d     = pc_q;
               ifid_instr_d  = imem_instr;
               ifid_valid_d  = 1'b1;
               pc_d          = pc_plus4;
               fetch_count_d = count_inc;
            end
         end

         // Terminal until reset; only the bubble is enforced.
         ST_HALT, ST_FAULT: begin
            ifid_valid_d = 1'b0;
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         ifid_pc_q     <= 64'h0;
         ifid_instr_q  <= 32'h0;
         ifid_valid_q  <= 1'b0;
         fault_q       <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_valid_q  <= ifid_valid_d;
         fault_q       <= fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_addr   = pc_q;
   assign ifid_pc     = ifid_pc_q;
   assign ifid_instr  = ifid_instr_q;
   assign ifid_valid  = ifid_valid_q;
   assign fault       = fault_q;
   assign fetch_count = fetch_count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage with IMEM_SIZE=1024, RESET_PC=0. The instruction
// memory is modelled as word = address XOR a pattern set by the stimulus.
// A behavioural model tracks the expected pipeline contents from the
// stage's rules and is compared against the DUT on every falling edge;
// directed scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam int unsigned IMEM_SIZE = 1024;

   // Model state codes (match the dbg_state encoding of the stage).
   localparam logic [1:0] M_BOOT  = 2'd0;
   localparam logic [1:0] M_RUN   = 2'd1;
   localparam logic [1:0] M_HALT  = 2'd2;
   localparam logic [1:0] M_FAULT = 2'd3;

   // ------------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [63:0] br_target;
   logic        halt_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        fault;
   logic [31:0] fetch_count;
   logic [1:0]  dbg_state;

   logic [31:0] imem_xor = 32'h0;

   always #5 clk = ~clk;

   fetch_stage #(
      .IMEM_SIZE (IMEM_SIZE),
      .RESET_PC  (64'h0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .halt_req    (halt_req),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .ifid_pc     (ifid_pc),
      .ifid_instr  (ifid_instr),
      .ifid_valid  (ifid_valid),
      .fault       (fault),
      .fetch_count (fetch_count),
      .dbg_state   (dbg_state)
   );

   function automatic logic [31:0] imem_word(input logic [63:0] a);
      return a[31:0] ^ imem_xor;
   endfunction

   always_comb imem_instr = imem_word(imem_addr);

   // ------------------------------------------------------------------------
   // Scoreboard counters and check helper
   // ------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   task automatic check64(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   logic [1:0]  m_state = M_BOOT;
   logic [63:0] m_pc    = 64'h0;
   logic [63:0] m_ifid_pc    = 64'h0;
   logic [31:0] m_ifid_instr = 32'h0;
   logic        m_valid = 1'b0;
   logic        m_fault = 1'b0;
   logic [31:0] m_count = 32'h0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state = M_BOOT; m_pc = 64'h0; m_ifid_pc = 64'h0;
         m_ifid_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'h0;
      end else if (m_state == M_BOOT) begin
         m_state = M_RUN;
      end else if (m_state == M_RUN) begin
         if ((m_pc % 4) != 0 || m_pc > 64'(IMEM_SIZE - 4)) begin
            m_state = M_FAULT; m_fault = 1'b1; m_valid = 1'b0;
         end else if (br_taken) begin
            m_pc = br_target; m_valid = 1'b0;
         end else if (halt_req) begin
            m_state = M_HALT; m_valid = 1'b0;
         end else if (!stall) begin
            m_ifid_pc    = m_pc;
            m_ifid_instr = imem_word(m_pc);
            m_valid      = 1'b1;
            m_pc         = m_pc + 64'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   logic cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         check64("cyc_imem_addr",   imem_addr,   m_pc);
         check64("cyc_ifid_pc",     ifid_pc,     m_ifid_pc);
         check64("cyc_ifid_instr",  64'(ifid_instr),  64'(m_ifid_instr));
         check64("cyc_ifid_valid",  64'(ifid_valid),  64'(m_valid));
         check64("cyc_fault",       64'(fault),       64'(m_fault));
         check64("cyc_fetch_count", 64'(fetch_count), 64'(m_count));
         check64("cyc_state",       64'(dbg_state),   64'(m_state));
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a posedge; leaves the stage in RUN with PC = 0.
   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(1);
   endtask

   task automatic check_reset_values(input string tag);
      check64({tag, "_imem_addr"},   imem_addr, 64'h0);
      check64({tag, "_ifid_pc"},     ifid_pc,   64'h0);
      check64({tag, "_ifid_instr"},  64'(ifid_instr),  64'h0);
      check64({tag, "_ifid_valid"},  64'(ifid_valid),  64'h0);
      check64({tag, "_fault"},       64'(fault),       64'h0);
      check64({tag, "_fetch_count"}, 64'(fetch_count), 64'h0);
      check64({tag, "_state"},       64'(dbg_state),   64'(M_BOOT));
   endtask

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0; halt_req = 1'b0;
      step(2);
      cmp_en = 1'b1;
      check_reset_values("por");

      // Boot then four RUN cycles, memory word = address.
      reset = 1'b0;
      step(1);
      check64("boot_state", 64'(dbg_state), 64'(M_RUN));
      check64("boot_no_load", 64'(ifid_valid), 64'h0);
      step(1);
      check64("first_load_valid", 64'(ifid_valid), 64'h1);
      check64("first_load_pc", ifid_pc, 64'h0);
      step(3);
      check64("run4_ifid_pc", ifid_pc, 64'h0C);
      check64("run4_ifid_instr", 64'(ifid_instr), 64'h0C);
      check64("run4_count", 64'(fetch_count), 64'd4);
      check64("run4_imem_addr", imem_addr, 64'h10);

      // Stall three cycles at PC 0x08.
      do_reset();
      step(2);
      stall = 1'b1;
      step(3);
      check64("stall_imem_addr", imem_addr, 64'h08);
      check64("stall_ifid_pc", ifid_pc, 64'h04);
      check64("stall_count", 64'(fetch_count), 64'd2);
      stall = 1'b0;
      step(1);
      check64("unstall_ifid_pc", ifid_pc, 64'h08);
      check64("unstall_count", 64'(fetch_count), 64'd3);

      // Redirect while stalled; scrambled memory words from here on.
      imem_xor = 32'h5A00_0000;
      stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
      step(1);
      br_taken = 1'b0; stall = 1'b0;
      check64("redir_imem_addr", imem_addr, 64'h40);
      check64("redir_valid", 64'(ifid_valid), 64'h0);
      check64("redir_pc_hold", ifid_pc, 64'h08);
      step(1);
      check64("redir_load_pc", ifid_pc, 64'h40);
      check64("redir_load_instr", 64'(ifid_instr), 64'h5A00_0040);
      check64("redir_load_valid", 64'(ifid_valid), 64'h1);

      // Redirect and halt together: redirect wins, halt taken next cycle.
      br_taken = 1'b1; br_target = 64'h80; halt_req = 1'b1;
      step(1);
      br_taken = 1'b0;
      check64("brhalt_imem_addr", imem_addr, 64'h80);
      check64("brhalt_state", 64'(dbg_state), 64'(M_RUN));
      step(1);
      halt_req = 1'b0;
      check64("halt_state", 64'(dbg_state), 64'(M_HALT));
      br_taken = 1'b1; br_target = 64'h100; stall = 1'b1;
      step(2);
      br_taken = 1'b0; stall = 1'b0;
      check64("halt_ignores_br", imem_addr, 64'h80);
      check64("halt_count", 64'(fetch_count), 64'd4);

      // Halt at PC 0x20, then asynchronous reset mid-HALT.
      do_reset();
      step(8);
      halt_req = 1'b1;
      step(1);
      halt_req = 1'b0;
      check64("halt20_valid", 64'(ifid_valid), 64'h0);
      check64("halt20_imem_addr", imem_addr, 64'h20);
      check64("halt20_ifid_pc", ifid_pc, 64'h1C);
      step(2);
      check64("halt20_frozen", imem_addr, 64'h20);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values("async");
      step(1);
      reset = 1'b0;
      step(1);

      // Misaligned, out-of-bounds redirect target.
      br_taken = 1'b1; br_target = 64'h3FE;
      step(1);
      br_taken = 1'b0;
      check64("badtgt_no_fault_yet", 64'(fault), 64'h0);
      check64("badtgt_imem_addr", imem_addr, 64'h3FE);
      step(1);
      check64("badtgt_fault", 64'(fault), 64'h1);
      check64("badtgt_state", 64'(dbg_state), 64'(M_FAULT));
      br_taken = 1'b1; br_target = 64'h0; stall = 1'b1;
      step(3);
      br_taken = 1'b0; stall = 1'b0;
      check64("fault_sticky", 64'(fault), 64'h1);
      check64("fault_pc_hold", imem_addr, 64'h3FE);

      // Misaligned but in-bounds target.
      do_reset();
      br_taken = 1'b1; br_target = 64'h102;
      step(1);
      br_taken = 1'b0;
      step(1);
      check64("misalign_fault", 64'(fault), 64'h1);

      // Sequential fetch to the last word, then off the end.
      do_reset();
      step(256);
      check64("end_ifid_pc", ifid_pc, 64'h3FC);
      check64("end_ifid_instr", 64'(ifid_instr), 64'h5A00_03FC);
      check64("end_no_fault", 64'(fault), 64'h0);
      check64("end_imem_addr", imem_addr, 64'h400);
      step(1);
      check64("oob_fault", 64'(fault), 64'h1);
      check64("oob_count", 64'(fetch_count), 64'd256);
      check64("oob_valid", 64'(ifid_valid), 64'h0);

      step(1);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
